// File: rtl/dff_reg.sv
// dff_reg: WIDTH-bit D register with async active-low clear, async set and sync load enable.
// Optional macro DFF_REG_QN_EN adds the inverted output qn_o.
module dff_reg #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]   SET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
`ifdef DFF_REG_QN_EN
    output logic [WIDTH-1:0] qn_o,
`endif
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    // Next state: load when enabled, otherwise hold
    always_comb begin
        q_d = en_i ? d_i : q_q;
    end
    // State register: clear beats set, set beats the clocked load
    always_ff @(posedge clk_i or negedge rst_i or posedge set_i) begin
        if (!rst_i)
            q_q <= RST_VAL;
        else if (set_i)
            q_q <= SET_VAL;
        else
            q_q <= q_d;
    end
    assign q_o = q_q;
`ifdef DFF_REG_QN_EN
    assign qn_o = ~q_q;
`endif
endmodule

// File: tb/tb_dff_reg.sv
// tb_dff_reg: scoreboard bench for dff_reg at WIDTH=8 and WIDTH=4 with custom reset/set values.
module tb_dff_reg;
    typedef struct {
        string      name;
        logic [7:0] exp;
        int         sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] d   = 8'h00;
    logic [7:0] q8;
    logic [3:0] q4;
    logic [3:0] qn4;
    exp_t       sb[$];
    int         issued = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    dff_reg dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .set_i (set),
        .en_i  (en),
        .d_i   (d),
`ifdef DFF_REG_QN_EN
        .qn_o  (),
`endif
        .q_o   (q8)
    );

    dff_reg #(.WIDTH(4), .RST_VAL(4'hA), .SET_VAL(4'h5)) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .set_i (set),
        .en_i  (en),
        .d_i   (d[3:0]),
`ifdef DFF_REG_QN_EN
        .qn_o  (qn4),
`endif
        .q_o   (q4)
    );

`ifndef DFF_REG_QN_EN
    assign qn4 = ~q4;
`endif

    task automatic chk(input string name, input logic [7:0] exp, input int sel);
        sb.push_back('{name, exp, sel});
        issued++;
    endtask

    // Monitor: drain every queued expectation against the outputs of this timestep
    always @(issued) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = sb.pop_front();
            act = (e.sel == 0) ? q8 : (e.sel == 1) ? {4'h0, q4} : {4'h0, qn4};
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h at t=%0t", e.name, act, e.exp, $time);
            end
        end
    end

    initial begin
        #2;
        chk("powerup_x", 8'hxx, 0);
        #11;
        rst = 1'b0;
        #1;
        chk("async_rst", 8'h00, 0);
        chk("rst4_q", 8'h0A, 1);
`ifdef DFF_REG_QN_EN
        chk("rst4_qn", 8'h05, 2);
`endif
        #1;
        @(negedge clk);
        rst = 1'b1;
        set = 1'b1;
        #1;
        chk("async_set", 8'hFF, 0);
        chk("set4_q", 8'h05, 1);
`ifdef DFF_REG_QN_EN
        chk("set4_qn", 8'h0A, 2);
`endif
        @(negedge clk);
        en = 1'b1;
        d  = 8'h12;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("set_hold_edges", 8'hFF, 0);
        #1;
        @(negedge clk);
        set = 1'b0;
        d   = 8'hAA;
        #1;
        chk("set_release_hold", 8'hFF, 0);
        #1;
        @(posedge clk);
        #1;
        chk("load_aa", 8'hAA, 0);
        chk("load4_a", 8'h0A, 1);
        #1;
        @(negedge clk);
        d = ~8'hAA;
        @(posedge clk);
        #1;
        chk("load_55", 8'h55, 0);
        chk("load4_5", 8'h05, 1);
        #1;
        @(negedge clk);
        en = 1'b0;
        d  = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("en_hold", 8'h55, 0);
            #1;
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("en_load_3c", 8'h3C, 0);
        chk("en_load4_c", 8'h0C, 1);
        #1;
        @(negedge clk);
        rst = 1'b0;
        set = 1'b1;
        #1;
        chk("prio_rst_over_set", 8'h00, 0);
        chk("prio4_rst", 8'h0A, 1);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("prio_set_after_rst", 8'hFF, 0);
        chk("prio4_set", 8'h05, 1);
        #1;
        @(negedge clk);
        set = 1'b0;
        en  = 1'b0;
        d   = 8'h12;
        @(posedge clk);
        #1;
        chk("set_drop_hold", 8'hFF, 0);
        #1;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("load_12", 8'h12, 0);
        chk("load4_2", 8'h02, 1);
`ifdef DFF_REG_QN_EN
        chk("load4_qn", 8'h0D, 2);
`endif
        #2;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dff_reg.md
Name: dff_reg

Overview:
- Parameterizable WIDTH-bit D flip-flop register with asynchronous clear, asynchronous set and a synchronous load enable.
- General-purpose storage primitive for datapath and control registers throughout the design.
- Single clock domain; all asynchronous controls act immediately on q_o without waiting for a clock edge.

Parameters:
- WIDTH, 8, bit width of d_i and q_o (minimum 1).
- RST_VAL, {WIDTH{1'b0}}, value forced onto q_o while reset is asserted.
- SET_VAL, {WIDTH{1'b1}}, value forced onto q_o while set is asserted.

Ports:
- clk_i  input  1  clock; rising edge active.
- rst_i  input  1  reset; asynchronous, active-low; forces q_o = RST_VAL.
- set_i  input  1  asynchronous set, active-high; forces q_o = SET_VAL.
- en_i  input  1  synchronous load enable, active-high; when en_i = 0, q_o holds.
- d_i  input  WIDTH  data input.
- q_o  output  WIDTH  registered data output.

Behaviour:
- Register state is q_o; it is updated in one always block sensitive to posedge clk_i, negedge rst_i and posedge set_i.
- Priority, highest first: reset, then set, then clocked load.
  - rst_i = 0: q_o = RST_VAL immediately, within the same timestep, with no clock required.
  - rst_i = 1 and set_i = 1: q_o = SET_VAL immediately and is held while set_i stays high; clock edges are ignored.
  - rst_i = 1, set_i = 0, rising clk_i edge with en_i = 1: q_o <= d_i.
  - Same conditions with en_i = 0: q_o holds its value.
- Latency: d_i appears on q_o at the first rising edge of clk_i with en_i = 1 (1 cycle).
- Simultaneous reset and set: reset wins and q_o = RST_VAL. When reset is released while set_i is still high, q_o goes to SET_VAL.
- Release of rst_i or set_i: q_o keeps the forced value until the next enabled rising edge.
- Power-up, before any reset: q_o is X in simulation; no implicit init value.
- Output is purely registered; no combinational path from d_i to q_o.
- X/Z on en_i during an edge is a usage error and is not required to be handled.

Optional Feature:
- Macro DFF_REG_QN_EN.
- Defined:
  - Adds output port qn_o (WIDTH bits), always equal to ~q_o.
  - qn_o is derived combinationally from the same state bits, so it obeys the same reset and set timing.
  - During reset, qn_o = ~RST_VAL; during set, qn_o = ~SET_VAL.
- Undefined: port qn_o does not exist; all other behaviour is identical.

Test Plan:
- Async reset:
  - Hold set_i = 0, clock running, q_o = X.
  - At t = 13 (mid-cycle) drive rst_i = 0.
  - Required: q_o = 8'h00 within 1 time unit, before any clock edge.
- Async set:
  - Release rst_i = 1 and drive set_i = 1 mid-cycle.
  - Required: q_o = 8'hFF within 1 time unit; q_o stays 8'hFF across subsequent clock edges while set_i = 1.
- Synchronous load:
  - Set rst_i = 1, set_i = 0, en_i = 1.
  - At a negedge drive d_i = 8'hAA; at the next posedge q_o = 8'hAA.
  - Then drive d_i = ~q_o; at the next posedge q_o = 8'h55.
- Enable hold:
  - With q_o = 8'h55, drive en_i = 0 and d_i = 8'h3C for 3 cycles.
  - Required: q_o stays 8'h55; raise en_i = 1 and q_o = 8'h3C after one edge.
- Priority:
  - Assert rst_i = 0 and set_i = 1 together: q_o = 8'h00.
  - Release rst_i = 1 with set_i still high: q_o = 8'hFF.
  - Drop set_i = 0: q_o holds 8'hFF until the next enabled edge.
- Parameters/option:
  - Instantiate WIDTH = 4, RST_VAL = 4'hA, SET_VAL = 4'h5 with DFF_REG_QN_EN defined.
  - Reset: q_o = 4'hA, qn_o = 4'h5.
  - Set: q_o = 4'h5, qn_o = 4'hA.
